// File: rtl/wormhole_switch_allocator.sv
// wormhole_switch_allocator
// Switch allocator and crossbar for the mesh NoC wormhole router. Each output
// port has its own round-robin arbiter. The winning flit is registered onto
// that output one cycle after the grant, and rd_en pops the granted input in
// the grant cycle.
// Optional feature macro: SA_PKT_LOCK_EN. When it is defined, an output that
// grants a head flit is locked to that input until the tail flit has been
// transferred. When it is undefined, every flit is arbitrated independently
// and the flit type bits are ignored (single-flit-packet builds).
module wormhole_switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int OP_SIZE   = 3,
  parameter int FLIT_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           empty,
  input  logic [NUM_PORTS*OP_SIZE-1:0]   op_port,
  input  logic [NUM_PORTS*FLIT_SIZE-1:0] in_buf,
  input  logic [NUM_PORTS-1:0]           ON_OFF_signal,
  output logic [NUM_PORTS-1:0]           rd_en,
  output logic [NUM_PORTS-1:0]           wr_en,
  output logic [NUM_PORTS*FLIT_SIZE-1:0] op_flit
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Round-robin pointer advance with wrap at NUM_PORTS.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(NUM_PORTS - 1)) r = {PW{1'b0}};
    else                         r = p + PW'(1'b1);
    return r;
  endfunction

`ifdef SA_PKT_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  localparam logic [1:0] FT_HEAD = 2'b01;

  // Tail and single flits both close a packet (type bit [1] set).
  function automatic logic is_tail(input logic [FLIT_SIZE-1:0] f);
    return f[FLIT_SIZE-1];
  endfunction

  function automatic logic is_head(input logic [FLIT_SIZE-1:0] f);
    return (f[FLIT_SIZE-1 -: 2] == FT_HEAD);
  endfunction

  state_e        state_r     [NUM_PORTS];
  state_e        state_nxt_s [NUM_PORTS];
  logic [PW-1:0] owner_r     [NUM_PORTS];
  logic [PW-1:0] owner_nxt_s [NUM_PORTS];
`endif

  logic [NUM_PORTS-1:0]           req_s [NUM_PORTS];  // req_s[o][i]
  logic [PW-1:0]                  scan_s [NUM_PORTS];
  logic [PW-1:0]                  win_s [NUM_PORTS];
  logic [FLIT_SIZE-1:0]           flit_s [NUM_PORTS];
  logic [PW-1:0]                  ptr_r [NUM_PORTS];
  logic [PW-1:0]                  ptr_nxt_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]           gnt_s;
  logic [NUM_PORTS-1:0]           rd_en_s;
  logic [NUM_PORTS-1:0]           wr_en_r;
  logic [NUM_PORTS*FLIT_SIZE-1:0] op_flit_r;

  // Request matrix: a non-empty input asks for the output its route names;
  // out-of-range route indices match no output and so raise no request.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_s[o][i] = !empty[i] && (op_port[i*OP_SIZE +: OP_SIZE] == OP_SIZE'(o));
      end
    end
  end

  // Round-robin scan from ptr upward. The loop runs backwards so the last
  // overwrite is the requester closest to ptr.
  always_comb begin
    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    sum_s = {(PW+1){1'b0}};
    idx_s = {PW{1'b0}};
    for (int o = 0; o < NUM_PORTS; o++) begin
      scan_s[o] = {PW{1'b0}};
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        sum_s     = {1'b0, ptr_r[o]} + (PW+1)'(k);
        idx_s     = (sum_s >= (PW+1)'(NUM_PORTS)) ? PW'(sum_s - (PW+1)'(NUM_PORTS)) : PW'(sum_s);
        scan_s[o] = req_s[o][idx_s] ? idx_s : scan_s[o];
      end
    end
  end

  // Per-output grant decision and next arbiter state.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_s[o]     = 1'b0;
      win_s[o]     = scan_s[o];
      ptr_nxt_s[o] = ptr_r[o];
`ifdef SA_PKT_LOCK_EN
      state_nxt_s[o] = state_r[o];
      owner_nxt_s[o] = owner_r[o];
      case (state_r[o])
        IDLE: begin
          if (ON_OFF_signal[o] && (|req_s[o])) begin
            gnt_s[o]       = 1'b1;
            ptr_nxt_s[o]   = ptr_inc(scan_s[o]);
            owner_nxt_s[o] = scan_s[o];
            // Only a head opens a lock; single, stray body and stray tail
            // flits are forwarded and leave the output idle.
            state_nxt_s[o] = is_head(in_buf[int'(scan_s[o])*FLIT_SIZE +: FLIT_SIZE]) ? LOCKED : IDLE;
          end else begin
            gnt_s[o] = 1'b0;
          end
        end
        LOCKED: begin
          win_s[o] = owner_r[o];
          if (ON_OFF_signal[o] && req_s[o][owner_r[o]]) begin
            gnt_s[o]       = 1'b1;
            state_nxt_s[o] = is_tail(in_buf[int'(owner_r[o])*FLIT_SIZE +: FLIT_SIZE]) ? IDLE : LOCKED;
          end else begin
            gnt_s[o] = 1'b0;
          end
        end
        default: begin
          state_nxt_s[o] = IDLE;
        end
      endcase
`else
      if (ON_OFF_signal[o] && (|req_s[o])) begin
        gnt_s[o]     = 1'b1;
        ptr_nxt_s[o] = ptr_inc(scan_s[o]);
      end else begin
        gnt_s[o] = 1'b0;
      end
`endif
      flit_s[o] = in_buf[int'(win_s[o])*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  // Input pops: OR of per-output one-hot grants, held off while in reset.
  always_comb begin
    rd_en_s = {NUM_PORTS{1'b0}};
    for (int o = 0; o < NUM_PORTS; o++) begin
      rd_en_s = rd_en_s | (gnt_s[o] ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << win_s[o])
                                    : {NUM_PORTS{1'b0}});
    end
    rd_en = rst ? rd_en_s : {NUM_PORTS{1'b0}};
  end

  // Arbiter state and registered crossbar output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        ptr_r[o] <= {PW{1'b0}};
`ifdef SA_PKT_LOCK_EN
        state_r[o] <= IDLE;
        owner_r[o] <= {PW{1'b0}};
`endif
      end
      wr_en_r   <= {NUM_PORTS{1'b0}};
      op_flit_r <= {(NUM_PORTS*FLIT_SIZE){1'b0}};
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        ptr_r[o] <= ptr_nxt_s[o];
`ifdef SA_PKT_LOCK_EN
        state_r[o] <= state_nxt_s[o];
        owner_r[o] <= owner_nxt_s[o];
`endif
        wr_en_r[o] <= gnt_s[o];
        if (gnt_s[o]) begin
          op_flit_r[o*FLIT_SIZE +: FLIT_SIZE] <= flit_s[o];
        end
      end
    end
  end

  assign wr_en   = wr_en_r;
  assign op_flit = op_flit_r;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Directed testbench for wormhole_switch_allocator (NUM_PORTS=5, OP_SIZE=3,
// FLIT_SIZE=8). Expected crossbar outputs are queued when a grant is
// expected and compared one cycle later. Expectations that depend on
// packet locking are selected by SA_PKT_LOCK_EN.
module tb_wormhole_switch_allocator;

  logic        clk;
  logic        rst;
  logic [4:0]  empty;
  logic [14:0] op_port;
  logic [39:0] in_buf;
  logic [4:0]  ON_OFF_signal;
  logic [4:0]  rd_en;
  logic [4:0]  wr_en;
  logic [39:0] op_flit;

  typedef struct packed {
    logic [4:0]  wr;
    logic [39:0] fl;
  } exp_t;

  exp_t        sb[$];
  logic [39:0] exp_last;
  int          checks;
  int          failures;

  wormhole_switch_allocator #(.NUM_PORTS(5), .OP_SIZE(3), .FLIT_SIZE(8)) dut (
    .clk(clk), .rst(rst), .empty(empty), .op_port(op_port), .in_buf(in_buf),
    .ON_OFF_signal(ON_OFF_signal), .rd_en(rd_en), .wr_en(wr_en), .op_flit(op_flit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int i, input logic [2:0] op, input logic [7:0] fl);
    empty[i]           = 1'b0;
    op_port[i*3 +: 3]  = op;
    in_buf[i*8 +: 8]   = fl;
  endtask

  task automatic drop(input int i);
    empty[i] = 1'b1;
  endtask

  // Called at posedge+1 with inputs set: checks rd_en mid-cycle, queues the
  // expected registered output, then checks it after the next edge.
  task automatic step(input string tag, input logic [4:0] exp_rd);
    exp_t       e;
    logic [2:0] o;
    #4;
    chk({tag, ".rd_en"}, 64'(rd_en), 64'(exp_rd));
    e.wr = 5'b00000;
    e.fl = exp_last;
    for (int i = 0; i < 5; i++) begin
      if (exp_rd[i]) begin
        o = op_port[i*3 +: 3];
        e.wr[o] = 1'b1;
        e.fl[o*8 +: 8] = in_buf[i*8 +: 8];
      end
    end
    exp_last = e.fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(e.wr));
    chk({tag, ".op_flit"}, 64'(op_flit), 64'(e.fl));
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_last      = 40'h0;
    rst           = 1'b0;
    empty         = 5'b11111;
    op_port       = 15'h0;
    in_buf        = 40'h0;
    ON_OFF_signal = 5'b11111;

    // Reset then idle
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("reset.rd_en", 64'(rd_en), 64'h0);
      chk("reset.wr_en", 64'(wr_en), 64'h0);
      chk("reset.op_flit", 64'(op_flit), 64'h0);
    end
    rst = 1'b1;
    step("idle", 5'b00000);

    // Contention on output 1: round robin 0, 2, 4
    set_in(0, 3'd1, 8'hC1);
    set_in(2, 3'd1, 8'hC2);
    set_in(4, 3'd1, 8'hC4);
    step("cont0", 5'b00001); drop(0);
    step("cont2", 5'b00100); drop(2);
    step("cont4", 5'b10000); drop(4);
    step("cont_end", 5'b00000);

    // Packet 4A/0B/8C from input 3 to output 0, input 1 competing
    set_in(3, 3'd0, 8'h4A);
    step("lock_head", 5'b01000);
    set_in(3, 3'd0, 8'h0B);
    set_in(1, 3'd0, 8'hD1);
`ifdef SA_PKT_LOCK_EN
    step("lock_body", 5'b01000);
    set_in(3, 3'd0, 8'h8C);
    step("lock_tail", 5'b01000); drop(3);
    step("lock_next", 5'b00010); drop(1);
`else
    step("rr_in1", 5'b00010); drop(1);
    step("rr_body", 5'b01000);
    set_in(3, 3'd0, 8'h8C);
    step("rr_tail", 5'b01000); drop(3);
`endif
    step("lock_end", 5'b00000);

    // Backpressure on output 2 after head from input 0
    set_in(0, 3'd2, 8'h41);
    step("bp_head", 5'b00001);
    set_in(0, 3'd2, 8'h02);
    set_in(3, 3'd2, 8'hE3);
    ON_OFF_signal[2] = 1'b0;
    step("bp_off1", 5'b00000);
    step("bp_off2", 5'b00000);
    step("bp_off3", 5'b00000);
    ON_OFF_signal[2] = 1'b1;
`ifdef SA_PKT_LOCK_EN
    step("bp_body", 5'b00001);
    set_in(0, 3'd2, 8'h83);
    step("bp_tail", 5'b00001); drop(0);
    step("bp_other", 5'b01000); drop(3);
`else
    step("bp_other", 5'b01000); drop(3);
    step("bp_body", 5'b00001);
    set_in(0, 3'd2, 8'h83);
    step("bp_tail", 5'b00001); drop(0);
`endif
    step("bp_end", 5'b00000);

    // Reset while a packet holds output 4
    set_in(2, 3'd4, 8'h51);
    step("rst_head", 5'b00100);
    set_in(2, 3'd4, 8'h12);
    rst = 1'b0;
    #1;
    chk("rst_async.rd_en", 64'(rd_en), 64'h0);
    chk("rst_async.wr_en", 64'(wr_en), 64'h0);
    chk("rst_async.op_flit", 64'(op_flit), 64'h0);
    sb.delete();
    exp_last = 40'h0;
    @(posedge clk);
    #1;
    chk("rst_hold.rd_en", 64'(rd_en), 64'h0);
    chk("rst_hold.wr_en", 64'(wr_en), 64'h0);
    drop(2);
    set_in(1, 3'd4, 8'h61);
    rst = 1'b1;
    step("rst_new_head", 5'b00010);
    set_in(1, 3'd4, 8'hA2);
    step("rst_new_tail", 5'b00010); drop(1);
    step("rst_end", 5'b00000);

    // Invalid route indices raise no request
    set_in(0, 3'd7, 8'hFF);
    step("inval7", 5'b00000);
    set_in(0, 3'd5, 8'hFE);
    step("inval5", 5'b00000);
    drop(0);
    step("inval_end", 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
